// File: rtl/integer_execute.sv
// Integer execute stage: single-cycle ALU with result bypass, branch/jump resolution,
// one-cycle fetch redirect on mispredict and registered ROB completion.
package iiq_pkg;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic            is_r_type;
        logic            is_sub;
        logic            is_sra_srai;
        logic            is_lui;
        logic            is_auipc;
        logic            is_jal;
        logic            is_jalr;
        logic            is_b_type;
        logic            br_dir_pred;
    } iiq_issue_data_t;
endpackage

module integer_execute #(
    parameter int unsigned XLEN         = iiq_pkg::XLEN,
    parameter int unsigned ROB_ID_WIDTH = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         issue_valid_i,
    input  logic [ROB_ID_WIDTH-1:0]      issue_rob_id_i,
    input  iiq_pkg::iiq_issue_data_t     issue_data_i,
    input  logic [ROB_ID_WIDTH-1:0]      rob_head_id_i,
    output logic                         alu_broadcast_valid_o,
    output logic [ROB_ID_WIDTH-1:0]      alu_broadcast_rob_id_o,
    output logic [XLEN-1:0]              alu_broadcast_reg_data_o,
    output logic                         rob_wb_valid_o,
    output logic [ROB_ID_WIDTH-1:0]      rob_wb_rob_id_o,
    output logic                         rob_wb_mispred_o,
    output logic                         fetch_redirect_valid_o,
    output logic [XLEN-1:0]              fetch_redirect_pc_o
);
    typedef enum logic {StRun, StSquash} state_e;

    iiq_pkg::iiq_issue_data_t d;
    state_e                   state_q;
    logic                     ex_valid_q, ex_valid_d;
    logic [ROB_ID_WIDTH-1:0]  ex_rob_id_q;
    logic                     rob_wb_valid_q, rob_wb_mispred_q;
    logic [ROB_ID_WIDTH-1:0]  rob_wb_rob_id_q;
    logic                     fetch_redirect_valid_q;
    logic [XLEN-1:0]          fetch_redirect_pc_q;

    logic [XLEN-1:0]          op_b, alu_res, result, jalr_sum, redirect_pc;
    logic [4:0]               shamt;
    logic                     taken, mispred, issue_older;
    logic [ROB_ID_WIDTH-1:0]  issue_age, ex_age;

    assign d = issue_data_i;

    always_comb begin
        op_b    = d.is_r_type ? d.src2 : d.imm;
        shamt   = op_b[4:0];
        alu_res = '0;
        unique case (d.funct3)
            3'b000: alu_res = (d.is_r_type & d.is_sub) ? d.src1 - op_b : d.src1 + op_b;
            3'b001: alu_res = d.src1 << shamt;
            3'b010: alu_res = XLEN'($signed(d.src1) < $signed(op_b));
            3'b011: alu_res = XLEN'(d.src1 < op_b);
            3'b100: alu_res = d.src1 ^ op_b;
            3'b101: alu_res = d.is_sra_srai ? $unsigned($signed(d.src1) >>> shamt)
                                            : d.src1 >> shamt;
            3'b110: alu_res = d.src1 | op_b;
            3'b111: alu_res = d.src1 & op_b;
        endcase

        if (d.is_lui)                    result = d.imm;
        else if (d.is_auipc)             result = d.pc + d.imm;
        else if (d.is_jal || d.is_jalr)  result = d.pc + XLEN'(4);
        else                             result = alu_res;
    end

    always_comb begin
        unique case (d.funct3)
            3'b000:  taken = (d.src1 == d.src2);
            3'b001:  taken = (d.src1 != d.src2);
            3'b100:  taken = ($signed(d.src1) < $signed(d.src2));
            3'b101:  taken = ($signed(d.src1) >= $signed(d.src2));
            3'b110:  taken = (d.src1 < d.src2);
            3'b111:  taken = (d.src1 >= d.src2);
            default: taken = 1'b0;
        endcase

        jalr_sum    = d.src1 + d.imm;
        redirect_pc = d.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                    : (taken ? d.pc + d.imm : d.pc + XLEN'(4));
        // A second mispredict cannot be taken while the first redirect is going out.
        mispred = ex_valid_q & (state_q == StRun)
                & ((d.is_b_type & (taken != d.br_dir_pred)) | d.is_jalr);
    end

    // Head-relative ages so wrap-around tags order correctly.
    always_comb begin
        issue_age   = issue_rob_id_i - rob_head_id_i;
        ex_age      = ex_rob_id_q - rob_head_id_i;
        issue_older = (issue_age < ex_age);

        if (state_q == StSquash) ex_valid_d = 1'b0;
        else if (mispred)        ex_valid_d = issue_valid_i & issue_older;
        else                     ex_valid_d = issue_valid_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q       <= 1'b0;
            ex_rob_id_q      <= '0;
            rob_wb_valid_q   <= 1'b0;
            rob_wb_rob_id_q  <= '0;
            rob_wb_mispred_q <= 1'b0;
        end else begin
            ex_valid_q       <= ex_valid_d;
            ex_rob_id_q      <= issue_rob_id_i;
            rob_wb_valid_q   <= ex_valid_q;
            rob_wb_rob_id_q  <= ex_rob_id_q;
            rob_wb_mispred_q <= mispred;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q                <= StRun;
            fetch_redirect_valid_q <= 1'b0;
            fetch_redirect_pc_q    <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mispred) begin
                        state_q                <= StSquash;
                        fetch_redirect_valid_q <= 1'b1;
                        fetch_redirect_pc_q    <= redirect_pc;
                    end else begin
                        fetch_redirect_valid_q <= 1'b0;
                    end
                end
                StSquash: begin
                    state_q                <= StRun;
                    fetch_redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_broadcast_valid_o    = ex_valid_q & ~d.is_b_type;
    assign alu_broadcast_rob_id_o   = alu_broadcast_valid_o ? ex_rob_id_q : '0;
    assign alu_broadcast_reg_data_o = alu_broadcast_valid_o ? result : '0;
    assign rob_wb_valid_o           = rob_wb_valid_q;
    assign rob_wb_rob_id_o          = rob_wb_rob_id_q;
    assign rob_wb_mispred_o         = rob_wb_mispred_q;
    assign fetch_redirect_valid_o   = fetch_redirect_valid_q;
    assign fetch_redirect_pc_o      = fetch_redirect_pc_q;

endmodule

// File: tb/tb_integer_execute.sv
// Bench for integer_execute: directed cases with literal expectations plus a random
// run checked every cycle against a transaction-level model.
module tb_integer_execute;
    import iiq_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             issue_valid = 1'b0;
    logic [4:0]       issue_rob_id = '0;
    iiq_issue_data_t  issue_data = '0;
    logic [4:0]       rob_head_id = '0;
    logic             bc_valid, wb_valid, wb_mis, rd_valid;
    logic [4:0]       bc_id, wb_id;
    logic [31:0]      bc_data, rd_pc;

    integer_execute #(.XLEN(32), .ROB_ID_WIDTH(5)) dut (
        .clk_i                    (clk),
        .rst_i                    (rst),
        .issue_valid_i            (issue_valid),
        .issue_rob_id_i           (issue_rob_id),
        .issue_data_i             (issue_data),
        .rob_head_id_i            (rob_head_id),
        .alu_broadcast_valid_o    (bc_valid),
        .alu_broadcast_rob_id_o   (bc_id),
        .alu_broadcast_reg_data_o (bc_data),
        .rob_wb_valid_o           (wb_valid),
        .rob_wb_rob_id_o          (wb_id),
        .rob_wb_mispred_o         (wb_mis),
        .fetch_redirect_valid_o   (rd_valid),
        .fetch_redirect_pc_o      (rd_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model state: instruction occupying EX now, and what it implies for next cycle.
    iiq_issue_data_t pend_data = '0;
    logic        m_ex_valid, n_ex_valid = 0, m_squash, n_squash = 0;
    logic [4:0]  m_ex_id, n_ex_id = 0, m_wb_id, n_wb_id = 0;
    logic        m_wb_valid, n_wb_valid = 0, m_wb_mis, n_wb_mis = 0;
    logic [31:0] m_rd_pc, n_rd_pc = 0;
    logic        e_bc_valid = 0, e_wb_valid = 0, e_wb_mis = 0, e_rd_valid = 0;
    logic [4:0]  e_bc_id = 0, e_wb_id = 0;
    logic [31:0] e_bc_data = 0, e_rd_pc = 0;
    logic [4:0]  head_v = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] f_sra(input logic [31:0] a, input int sh);
        logic [31:0] r = a;
        for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] f_result(input iiq_issue_data_t x);
        logic [31:0] b;
        int sh;
        if (x.is_lui) return x.imm;
        if (x.is_auipc) return x.pc + x.imm;
        if (x.is_jal || x.is_jalr) return x.pc + 32'd4;
        b  = x.is_r_type ? x.src2 : x.imm;
        sh = int'(b % 32);
        case (x.funct3)
            3'd0: return (x.is_r_type && x.is_sub) ? x.src1 - b : x.src1 + b;
            3'd1: return x.src1 << sh;
            3'd2: return ($signed(x.src1) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (x.src1 < b) ? 32'd1 : 32'd0;
            3'd4: return x.src1 ^ b;
            3'd5: return x.is_sra_srai ? f_sra(x.src1, sh) : x.src1 >> sh;
            3'd6: return x.src1 | b;
            default: return x.src1 & b;
        endcase
    endfunction

    function automatic bit f_taken(input iiq_issue_data_t x);
        int signed a = x.src1, b = x.src2;
        case (x.funct3)
            3'd0: return x.src1 == x.src2;
            3'd1: return x.src1 != x.src2;
            3'd4: return a < b;
            3'd5: return a >= b;
            3'd6: return x.src1 < x.src2;
            3'd7: return x.src1 >= x.src2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit f_mispred(input iiq_issue_data_t x);
        if (x.is_jalr) return 1'b1;
        if (x.is_b_type) return f_taken(x) != x.br_dir_pred;
        return 1'b0;
    endfunction

    function automatic logic [31:0] f_target(input iiq_issue_data_t x);
        if (x.is_jalr) return (x.src1 + x.imm) & 32'hFFFF_FFFE;
        return f_taken(x) ? x.pc + x.imm : x.pc + 32'd4;
    endfunction

    function automatic bit f_older(input logic [4:0] a, input logic [4:0] b, input logic [4:0] h);
        return ((int'(a) - int'(h) + 32) % 32) < ((int'(b) - int'(h) + 32) % 32);
    endfunction

    task automatic model_reset();
        n_ex_valid = 0; n_ex_id = 0; n_squash = 0; n_rd_pc = 0;
        n_wb_valid = 0; n_wb_id = 0; n_wb_mis = 0; pend_data = '0;
    endtask

    // One clock: drive issue of 'ins' with tag 'id', compute expectations, return after negedge.
    task automatic step(input logic v, input logic [4:0] id, input iiq_issue_data_t ins);
        bit mis;
        @(posedge clk); #1;
        m_ex_valid = n_ex_valid; m_ex_id = n_ex_id; m_squash = n_squash; m_rd_pc = n_rd_pc;
        m_wb_valid = n_wb_valid; m_wb_id = n_wb_id; m_wb_mis = n_wb_mis;
        issue_valid = v; issue_rob_id = id; rob_head_id = head_v;
        issue_data = pend_data;
        e_bc_valid = m_ex_valid && !pend_data.is_b_type;
        e_bc_id    = m_ex_id;
        e_bc_data  = f_result(pend_data);
        e_wb_valid = m_wb_valid; e_wb_id = m_wb_id; e_wb_mis = m_wb_mis;
        e_rd_valid = m_squash;   e_rd_pc = m_rd_pc;
        mis = m_ex_valid && !m_squash && f_mispred(pend_data);
        n_wb_valid = m_ex_valid; n_wb_id = m_ex_id; n_wb_mis = mis;
        n_squash = mis; n_rd_pc = f_target(pend_data);
        n_ex_id = id;
        if (m_squash)  n_ex_valid = 1'b0;
        else if (mis)  n_ex_valid = v && f_older(id, m_ex_id, head_v);
        else           n_ex_valid = v;
        pend_data = ins;
        @(negedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bc_valid", 32'(bc_valid), 32'(e_bc_valid));
            if (e_bc_valid) begin
                chk("bc_id", 32'(bc_id), 32'(e_bc_id));
                chk("bc_data", bc_data, e_bc_data);
            end
            chk("wb_valid", 32'(wb_valid), 32'(e_wb_valid));
            if (e_wb_valid) begin
                chk("wb_id", 32'(wb_id), 32'(e_wb_id));
                chk("wb_mispred", 32'(wb_mis), 32'(e_wb_mis));
            end
            chk("redirect_valid", 32'(rd_valid), 32'(e_rd_valid));
            if (e_rd_valid) chk("redirect_pc", rd_pc, e_rd_pc);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_valids"}, {28'd0, bc_valid, wb_valid, rd_valid, wb_mis}, 32'd0);
        chk({tag, "_ids"}, {22'd0, bc_id, wb_id}, 32'd0);
        chk({tag, "_bc_data"}, bc_data, 32'd0);
        chk({tag, "_rd_pc"}, rd_pc, 32'd0);
    endtask

    function automatic iiq_issue_data_t mk_alu(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b, input bit r, input bit alt);
        iiq_issue_data_t x = '0;
        x.funct3 = f3; x.src1 = a; x.is_r_type = r;
        if (r) x.src2 = b; else x.imm = b;
        x.is_sub = alt; x.is_sra_srai = alt;
        return x;
    endfunction

    function automatic iiq_issue_data_t mk_br(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b, input bit pred,
                                              input logic [31:0] pc, input logic [31:0] imm);
        iiq_issue_data_t x = '0;
        x.is_b_type = 1'b1; x.funct3 = f3; x.src1 = a; x.src2 = b;
        x.br_dir_pred = pred; x.pc = pc; x.imm = imm;
        return x;
    endfunction

    function automatic iiq_issue_data_t rand_instr();
        iiq_issue_data_t x = '0;
        int k = $urandom_range(0, 9);
        x.pc = $urandom & 32'hFFFF_FFFC;
        x.src1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        x.src2 = ($urandom_range(0, 3) == 0) ? x.src1 : $urandom;
        x.imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
        x.funct3 = 3'($urandom);
        x.is_sub = 1'($urandom); x.is_sra_srai = 1'($urandom);
        x.br_dir_pred = 1'($urandom);
        case (k)
            0, 1:  x.is_r_type = 1'b1;
            2, 3:  x.is_r_type = 1'b0;
            4:     x.is_lui = 1'b1;
            5:     x.is_auipc = 1'b1;
            6:     x.is_jal = 1'b1;
            7:     x.is_jalr = 1'b1;
            default: x.is_b_type = 1'b1;
        endcase
        return x;
    endfunction

    iiq_issue_data_t nop, jx;

    initial begin
        nop = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;
        model_reset();
        #1 chk_en = 1'b1;

        // add and back-to-back ALU ops
        step(1, 5'd3, mk_alu(3'd0, 32'd5, 32'd7, 1, 0));
        step(0, 5'd0, nop);
        chk("add_bc", bc_data, 32'd12); chk("add_bc_id", 32'(bc_id), 32'd3);
        step(1, 5'd1, mk_alu(3'd0, 32'd3, 32'd5, 1, 1));
        chk("add_wb", {26'd0, wb_valid, wb_id}, {26'd0, 1'b1, 5'd3});
        step(1, 5'd2, mk_alu(3'd5, 32'h8000_0000, 32'd4, 0, 1));
        chk("sub", bc_data, 32'hFFFF_FFFE);
        step(1, 5'd4, mk_alu(3'd3, 32'd1, 32'hFFFF_FFFF, 1, 0));
        chk("sra", bc_data, 32'hF800_0000);
        step(0, 5'd0, nop);
        chk("sltu", bc_data, 32'd1);

        // beq taken, predicted not-taken
        step(1, 5'd10, mk_br(3'd0, 32'd9, 32'd9, 0, 32'h100, 32'h20));
        step(0, 5'd0, nop);
        chk("beq_no_bc", 32'(bc_valid), 32'd0);
        step(0, 5'd0, nop);
        chk("beq_redirect", {31'd0, rd_valid}, 32'd1); chk("beq_pc", rd_pc, 32'h120);
        chk("beq_wb_mis", {30'd0, wb_valid, wb_mis}, 32'd3);
        step(0, 5'd0, nop);
        chk("beq_one_pulse", {31'd0, rd_valid}, 32'd0);

        // younger issued in detect cycle and another in SQUASH: both dropped
        step(1, 5'd10, mk_br(3'd1, 32'd1, 32'd1, 1, 32'h200, 32'h40));
        step(1, 5'd12, mk_alu(3'd0, 32'd1, 32'd1, 1, 0));
        step(1, 5'd13, mk_alu(3'd0, 32'd2, 32'd2, 1, 0));
        chk("young_squash_bc", 32'(bc_valid), 32'd0); chk("squash_pc", rd_pc, 32'h204);
        step(0, 5'd0, nop);
        chk("squash_issue_bc", 32'(bc_valid), 32'd0); chk("young_wb", 32'(wb_valid), 32'd0);
        step(0, 5'd0, nop);
        chk("squash_issue_wb", 32'(wb_valid), 32'd0);

        // older (wrapped tag) issued in detect cycle survives
        head_v = 5'd28;
        step(1, 5'd2, mk_br(3'd1, 32'd1, 32'd1, 1, 32'h200, 32'h40));
        step(1, 5'd30, mk_alu(3'd0, 32'd5, 32'd7, 1, 0));
        step(0, 5'd0, nop);
        chk("older_bc", {26'd0, bc_valid, bc_id}, {26'd0, 1'b1, 5'd30});
        step(0, 5'd0, nop);
        chk("older_wb", {26'd0, wb_valid, wb_id}, {26'd0, 1'b1, 5'd30});
        head_v = 5'd0;

        // jalr always redirects, jal never
        jx = '0; jx.is_jalr = 1'b1; jx.pc = 32'h40; jx.src1 = 32'h203; jx.imm = 32'd4;
        step(1, 5'd5, jx);
        step(0, 5'd0, nop);
        chk("jalr_link", bc_data, 32'h44);
        step(0, 5'd0, nop);
        chk("jalr_pc", rd_pc, 32'h206); chk("jalr_mis", 32'(wb_mis), 32'd1);
        jx = '0; jx.is_jal = 1'b1; jx.pc = 32'h80; jx.imm = 32'h100;
        step(1, 5'd6, jx);
        step(0, 5'd0, nop);
        chk("jal_link", bc_data, 32'h84);
        step(0, 5'd0, nop);
        chk("jal_no_redirect", {30'd0, rd_valid, wb_mis}, 32'd0);

        // reset asserted in SQUASH with an older instruction in EX
        step(1, 5'd10, mk_br(3'd0, 32'd1, 32'd2, 1, 32'h300, 32'h8));
        step(1, 5'd8, mk_alu(3'd0, 32'd5, 32'd7, 1, 0));
        step(0, 5'd0, nop);
        chk("pre_rst_state", {30'd0, rd_valid, bc_valid}, 32'd3);
        chk_en = 1'b0;
        rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(posedge clk); @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b0;
        model_reset();
        #1 chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 5'd0, nop);
            chk("post_rst_no_pulse", {31'd0, rd_valid}, 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            head_v = 5'($urandom);
            step(($urandom_range(0, 9) < 7), 5'($urandom), rand_instr());
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
